step_control_unit: RTL

//  Sequencing controller for the 16-bit single-cycle processor datapath. It debounces the

---
 rtl/step_control_unit_if.sv | 30 +++
 rtl/step_control_unit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/step_control_unit_if.sv
// Datapath-facing bundle of the step controller: button, switch mode,
// current instruction in; decoded control lines, state and count out.
interface step_control_unit_if;
   logic        next_btn;
   logic        switch;
   logic [15:0] instruction;
   logic        writePc;
   logic        memToReg;
   logic        jumpEnable;
   logic        aluCtrl;
   logic        writeDst;
   logic        writeFromIns;
   logic        writeMemory;
   logic        writeReg;
   logic        next;
   logic [1:0]  state;
   logic [7:0]  retired;

   modport master (
      output next_btn, switch, instruction,
      input  writePc, memToReg, jumpEnable, aluCtrl, writeDst,
      input  writeFromIns, writeMemory, writeReg, next, state, retired
   );

   modport slave (
      input  next_btn, switch, instruction,
      output writePc, memToReg, jumpEnable, aluCtrl, writeDst,
      output writeFromIns, writeMemory, writeReg, next, state, retired
   );
endinterface

// File: rtl/step_control_unit.sv
// Single-step sequencer: debounced NEXT press runs one instruction
// through IDLE -> DECODE -> EXEC, with a sticky HALT on opcode 111.
module step_control_unit #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 20
) (
   input logic                clk,
   input logic                reset,
   step_control_unit_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_DECODE = 2'b01,
      S_EXEC   = 2'b10,
      S_HALT   = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q, sync_prev_q;
   logic             stable_q, stable_d;
   logic             stable_dly_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_t           state_q, state_d;
   logic [15:0]      ir_q, ir_d;
   logic [7:0]       retired_q, retired_d;
   logic             step_req;

   // Count only while the synchronised level differs from the accepted
   // level and has not moved since the previous cycle.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q == stable_q || sync2_q != sync_prev_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         stable_d = sync2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign step_req = stable_q & ~stable_dly_q;

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      unique case (state_q)
         S_IDLE: begin
            if (step_req) begin
               ir_d    = bus.instruction;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = (ir_q[15:13] == 3'b111) ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            retired_d = retired_q + 8'd1;
            state_d   = S_IDLE;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         sync_prev_q  <= 1'b0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         cnt_q        <= '0;
         state_q      <= S_IDLE;
         ir_q         <= '0;
         retired_q    <= '0;
      end else begin
         sync1_q      <= bus.next_btn;
         sync2_q      <= sync1_q;
         sync_prev_q  <= sync2_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         ir_q         <= ir_d;
         retired_q    <= retired_d;
      end
   end

   logic wr_reg, wr_mem, mem2reg, dst, alu, from_ins, jmp;

   always_comb begin
      wr_reg   = 1'b0;
      wr_mem   = 1'b0;
      mem2reg  = 1'b0;
      dst      = 1'b0;
      alu      = 1'b0;
      from_ins = 1'b0;
      jmp      = 1'b0;
      unique case (ir_q[15:13])
         3'b000: begin wr_reg = 1'b1; mem2reg = 1'b1; dst = 1'b1; end
         3'b001: begin wr_mem = 1'b1; dst = 1'b1; end
         3'b010: begin wr_reg = 1'b1; end
         3'b011: begin wr_reg = 1'b1; alu = 1'b1; end
         3'b100: begin wr_mem = 1'b1; from_ins = 1'b1; dst = 1'b1; end
         3'b101: begin wr_reg = 1'b1; from_ins = 1'b1; dst = 1'b1; end
         3'b110: begin jmp = 1'b1; alu = 1'b1; end
         3'b111: begin end
      endcase
   end

   logic lvl_en, exec;
   assign lvl_en = (state_q == S_DECODE) || (state_q == S_EXEC);
   assign exec   = (state_q == S_EXEC);

   assign bus.memToReg     = lvl_en & mem2reg;
   assign bus.writeDst     = lvl_en & dst;
   assign bus.aluCtrl      = lvl_en & alu;
   assign bus.writeFromIns = lvl_en & from_ins;
   assign bus.jumpEnable   = lvl_en & jmp;
   assign bus.writeReg     = exec & wr_reg;
   assign bus.writeMemory  = exec & wr_mem;
   assign bus.writePc      = exec & ~bus.switch;
   assign bus.next         = exec & ~bus.switch;
   assign bus.state        = state_q;
   assign bus.retired      = retired_q;
endmodule
